// File: rtl/param_sync_fifo_pkg.sv
// Shared sizing helpers and read-mode constants for the synchronous FIFO family.
package param_sync_fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    function automatic int fifo_depth(input int awidth);
        return 1 << awidth;
    endfunction

    function automatic int fifo_cwidth(input int awidth);
        return awidth + 1;
    endfunction

endpackage

// File: rtl/param_sync_fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one asynchronous read port.
module param_sync_fifo_mem
    import param_sync_fifo_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [AWIDTH-1:0] i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    localparam int DEPTH = fifo_depth(AWIDTH);

    logic [DWIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// rejected-request error pulses and selectable registered or FWFT read mode.
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int DWIDTH   = 8,
    parameter int AWIDTH   = 4,
    parameter int AF_LEVEL = (1 << AWIDTH) - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = FWFT_OFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [AWIDTH:0]   count,
    output logic              wr_err,
    output logic              rd_err
);

    localparam int DEPTH  = fifo_depth(AWIDTH);
    localparam int CWIDTH = fifo_cwidth(AWIDTH);
    localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);
    localparam logic [CWIDTH-1:0] CNT_ONE = CWIDTH'(1);

    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [CWIDTH-1:0] r_count;
    logic              r_wr_err;
    logic              r_rd_err;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic [DWIDTH-1:0] w_rd_data;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
    assign w_rd_ok = re && !empty;
    assign w_wr_ok = we && (!full || w_rd_ok);

    param_sync_fifo_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (din),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_wr_err <= we && !w_wr_ok;
            r_rd_err <= re && !w_rd_ok;
        end
    end

    assign count        = r_count;
    assign empty        = (r_count == '0);
    assign full         = (r_count == CWIDTH'(DEPTH));
    assign almost_empty = (r_count <= CWIDTH'(AE_LEVEL));
    assign almost_full  = (r_count >= CWIDTH'(AF_LEVEL));
    assign wr_err       = r_wr_err;
    assign rd_err       = r_rd_err;

    generate
        if (FWFT == FWFT_ON) begin : g_fwft
            assign dout = empty ? '0 : w_rd_data;
        end else begin : g_reg
            logic [DWIDTH-1:0] r_dout;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_dout <= '0;
                end else if (w_rd_ok) begin
                    r_dout <= w_rd_data;
                end
            end
            assign dout = r_dout;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Drives a registered-read and an FWFT instance with identical stimulus and
// checks both against a queue model of the FIFO contents.
module tb_param_sync_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic          re;
    logic [DW-1:0] din;

    logic [DW-1:0] r_dout, f_dout;
    logic          r_empty, f_empty, r_full, f_full;
    logic          r_ae, f_ae, r_af, f_af;
    logic [AW:0]   r_count, f_count;
    logic          r_werr, f_werr, r_rerr, f_rerr;

    int            n_total = 0;
    int            n_bad   = 0;
    logic [DW-1:0] mq[$];
    logic [DW-1:0] last_dout;
    bit            reset_done;

    always #5 clk = ~clk;

    param_sync_fifo #(.DWIDTH(DW), .AWIDTH(AW), .FWFT(0)) u_reg (
        .clk(clk), .rst(rst), .we(we), .re(re), .din(din),
        .dout(r_dout), .empty(r_empty), .full(r_full),
        .almost_empty(r_ae), .almost_full(r_af), .count(r_count),
        .wr_err(r_werr), .rd_err(r_rerr)
    );

    param_sync_fifo #(.DWIDTH(DW), .AWIDTH(AW), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .we(we), .re(re), .din(din),
        .dout(f_dout), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
        .wr_err(f_werr), .rd_err(f_rerr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input logic exp_werr, input logic exp_rerr);
        int            c;
        logic [DW-1:0] head;
        c    = mq.size();
        head = (c == 0) ? '0 : mq[0];
        chk("reg_count",  32'(r_count), 32'(c));
        chk("reg_empty",  32'(r_empty), 32'(c == 0));
        chk("reg_full",   32'(r_full),  32'(c == DEPTH));
        chk("reg_aempty", 32'(r_ae),    32'(c <= 2));
        chk("reg_afull",  32'(r_af),    32'(c >= 14));
        chk("reg_wr_err", 32'(r_werr),  32'(exp_werr));
        chk("reg_rd_err", 32'(r_rerr),  32'(exp_rerr));
        chk("reg_dout",   32'(r_dout),  32'(last_dout));
        chk("fwft_count", 32'(f_count), 32'(c));
        chk("fwft_empty", 32'(f_empty), 32'(c == 0));
        chk("fwft_full",  32'(f_full),  32'(c == DEPTH));
        chk("fwft_wr_err",32'(f_werr),  32'(exp_werr));
        chk("fwft_rd_err",32'(f_rerr),  32'(exp_rerr));
        chk("fwft_dout",  32'(f_dout),  32'(head));
    endtask

    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        logic acc_rd, acc_wr;
        acc_rd = r && (mq.size() != 0);
        acc_wr = w && ((mq.size() < DEPTH) || acc_rd);
        we  = w;
        re  = r;
        din = d;
        @(posedge clk);
        #1;
        if (acc_rd) last_dout = mq.pop_front();
        if (acc_wr) mq.push_back(d);
        we = 1'b0;
        re = 1'b0;
        check_all(w && !acc_wr, r && !acc_rd);
    endtask

    // Request lines are held active during reset to show reset wins.
    task automatic do_reset();
        rst = 1'b0;
        we  = 1'b1;
        re  = 1'b1;
        din = 8'hEE;
        @(posedge clk);
        #1;
        rst = 1'b1;
        we  = 1'b0;
        re  = 1'b0;
        mq.delete();
        last_dout = '0;
        check_all(1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; re = 1'b0; din = '0;
        last_dout = '0;
        reset_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 8'h99);
        step(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
        step(1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
        chk("aa_last", 32'(r_dout), 32'h0000_00AA);

        step(1'b1, 1'b1, 8'h55);
        step(1'b0, 1'b1, 8'h00);
        chk("r55_dout", 32'(r_dout), 32'h0000_0055);

        step(1'b1, 1'b0, 8'h3C);
        chk("fwft_3c", 32'(f_dout), 32'h0000_003C);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        chk("fwft_pop", 32'(f_dout), 32'h0000_0000);

        for (int i = 0; i < 150; i++) step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 8'($urandom));
        for (int i = 0; i < 150; i++) step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));

        for (int i = 0; i < 20; i++) begin
            step(1'b1, (i % 3 == 2), 8'(8'h60 + i));
            if (!reset_done && mq.size() == 7) begin
                do_reset();
                reset_done = 1'b1;
            end
        end
        chk("mid_reset_hit", 32'(reset_done), 32'd1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
